// File: rtl/gcd_engine.sv
// Subtractive GCD engine: one subtract per cycle with a valid/ready handshake
// on both sides. Operands containing a zero short-circuit straight to DONE.
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] steps_out,
    output logic             err_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic             accept, any_zero;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid && !clear;
    assign any_zero  = (a_in == '0) || (b_in == '0);
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = any_zero ? DONE : CALC;
            CALC:    if (a_q == b_q) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            gcd_out   <= '0;
            steps_out <= '0;
            err_zero  <= 1'b0;
        end else if (accept) begin
            a_q      <= a_in;
            b_q      <= b_in;
            cnt      <= '0;
            err_zero <= (a_in == '0) && (b_in == '0);
            // Zero operands finish at accept; OR of the pair picks the nonzero one.
            if (any_zero) begin
                gcd_out   <= a_in | b_in;
                steps_out <= '0;
            end
        end else if (state == CALC && !clear) begin
            if (a_q == b_q) begin
                gcd_out   <= a_q;
                steps_out <= cnt;
            end else if (a_q > b_q) begin
                a_q <= a_q - b_q;
                cnt <= cnt_inc;
            end else begin
                b_q <= b_q - a_q;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Randomized scoreboard bench for gcd_engine: a driver pushes Euclid-model
// results into a queue and a monitor pops them on every completed transfer.
module tb_gcd_engine;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] gcd;
        logic [W-1:0] steps;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] gcd_out;
    logic [W-1:0] steps_out;
    logic         err_zero;

    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    gcd_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .gcd_out(gcd_out), .steps_out(steps_out), .err_zero(err_zero)
    );

    always #5 clk = ~clk;

    // Euclid by division; subtractive steps = sum of quotients minus one.
    function automatic exp_t model(input int unsigned a, input int unsigned b);
        exp_t e;
        int unsigned x, y, t, s;
        e.err = (a == 0) && (b == 0);
        if (a == 0 || b == 0) begin
            e.gcd = W'(a + b);
            e.steps = '0;
            return e;
        end
        x = a; y = b; s = 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        s -= 1;
        e.gcd = W'(x);
        e.steps = (s > (2**W - 1)) ? '1 : W'(s);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got gcd %0d with no result pending", gcd_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (gcd_out !== e.gcd || steps_out !== e.steps || err_zero !== e.err) begin
                    fails++;
                    $display("FAIL result: got gcd=%0d steps=%0d err=%0d, expected gcd=%0d steps=%0d err=%0d",
                             gcd_out, steps_out, err_zero, e.gcd, e.steps, e.err);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Wait for in_ready, hand over operands, optionally check latency to out_valid.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit chk_lat, input bit track);
        exp_t e;
        int n;
        e = model(a, b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        a_in = a; b_in = b; in_valid = 1'b1;
        if (track) sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!chk_lat) return;
        n = 1;
        while (!out_valid && n < 2000) begin @(posedge clk); #1; n++; end
        check($sformatf("latency_%0d_%0d", a, b), n,
              ((a == 0) || (b == 0)) ? 1 : 2 + int'(e.steps));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) check("drain_timeout", 0, 1);
    endtask

    initial begin
        exp_t e;
        #2;
        check("rst_in_ready", in_ready, 1);
        in_valid = 1'b1; a_in = 8'd6; b_in = 8'd4;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_state_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_gcd", gcd_out, 0);
        check("rst_steps", steps_out, 0);
        check("rst_err", err_zero, 0);

        send(8'd12, 8'd8, 1, 1);   drain();
        send(8'd7, 8'd7, 1, 1);    drain();
        send(8'd0, 8'd9, 1, 1);    drain();
        send(8'd0, 8'd0, 1, 1);    drain();
        send(8'd9, 8'd0, 1, 1);    drain();
        send(8'd255, 8'd1, 1, 1);  drain();
        send(8'd1, 8'd255, 1, 1);  drain();

        // Consumer stalls in DONE: outputs must hold and new operands be ignored.
        out_ready = 1'b0;
        e = model(13, 5);
        send(8'd13, 8'd5, 1, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a_in = 8'd40; b_in = 8'd8;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_gcd", gcd_out, e.gcd);
            check("hold_steps", steps_out, e.steps);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready, 1);
        drain();

        // Clear mid-computation; the engine must come back idle with no result.
        send(8'd100, 8'd3, 0, 0);
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_idle", in_ready, 1);
        check("clear_no_valid", out_valid, 0);
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("clear_spurious_valid", out_valid, 0);
        end

        // clear together with in_valid in IDLE must not accept.
        clear = 1'b1; in_valid = 1'b1; a_in = 8'd12; b_in = 8'd18;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clear_blocks_accept", in_ready, 1);
        @(posedge clk); #1;
        check("clear_blocks_valid", out_valid, 0);

        // Asynchronous reset mid-computation clears outputs immediately.
        send(8'd100, 8'd3, 0, 0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_gcd", gcd_out, 0);
        check("arst_steps", steps_out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        in_valid = 1'b1; a_in = 8'd5; b_in = 8'd10;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_ignored_in", in_ready, 1);

        // Randomized traffic with random consumer back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            send(ra, rb, 1, 1);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port clear  input  1  synchronous abort; returns engine to IDLE.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  engine accepts operands this cycle.
REQ-007 SHALL have port a_in  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b_in  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port out_valid  output  1  result held on outputs.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port gcd_out  output  WIDTH  greatest common divisor.
REQ-012 SHALL have port steps_out  output  WIDTH  subtraction count, saturating at all-ones.
REQ-013 SHALL have port err_zero  output  1  both operands were zero.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE (decoded from state); out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid=1, SHALL register a_in->A, b_in->B, clear step counter, clear err_zero.
REQ-017 IDLE accept with both nonzero SHALL move to CALC next edge.
REQ-018 IDLE accept with exactly one zero SHALL move directly to DONE with gcd_out = the nonzero operand, steps_out = 0.
REQ-019 IDLE accept with both zero SHALL move directly to DONE with gcd_out = 0, steps_out = 0, err_zero = 1.
REQ-020 CALC, per cycle: A==B -> gcd_out<=A, go DONE; A>B -> A<=A-B; A<B -> B<=B-A.
REQ-021 Each CALC subtract cycle SHALL increment the step counter by 1, saturating at 2^WIDTH-1.
REQ-022 Subtraction SHALL be WIDTH-bit unsigned; larger-minus-smaller only, so no underflow occurs.
REQ-023 Latency: accept at edge T; nonzero result valid at T+2+steps; zero-operand result valid at T+1.
REQ-024 DONE SHALL hold gcd_out, steps_out, err_zero stable until out_ready=1, then go IDLE next edge.
REQ-025 gcd_out, steps_out, err_zero SHALL be registered and retain last values in IDLE and CALC.
REQ-026 in_valid outside IDLE SHALL be ignored; no operand queueing.
REQ-027 clear=1 SHALL force IDLE next edge from any state, discard any partial or unconsumed result, and deassert out_valid; clear has priority over all handshakes.
REQ-028 clear=1 and in_valid=1 together in IDLE SHALL NOT accept the operands.
REQ-029 Simultaneous out_valid and out_ready SHALL complete the transfer in that cycle; in_ready rises the following cycle.

Reset
REQ-030 rst_n=0 SHALL immediately set state IDLE, A=B=0, step counter 0, gcd_out=0, steps_out=0, err_zero=0, out_valid=0.
REQ-031 in_ready SHALL read 1 during and after reset (state IDLE); in_valid SHALL be ignored while rst_n=0.
REQ-032 Reset asserted mid-CALC or in DONE SHALL abandon the computation with no result delivered.

Verification
REQ-033 a=12, b=8, out_ready=1 -> out_valid at T+4, gcd_out=4, steps_out=2, err_zero=0.
REQ-034 a=b=0x0007 -> out_valid at T+2, gcd_out=7, steps_out=0.
REQ-035 a=0, b=9 -> out_valid at T+1, gcd_out=9; a=0, b=0 -> gcd_out=0, err_zero=1.
REQ-036 a=13, b=5, out_ready held 0 for 10 cycles in DONE -> gcd_out=1, steps_out=5 stable throughout; in_ready=0 throughout; new in_valid ignored.
REQ-037 WIDTH=8, a=255, b=1 -> gcd_out=1, steps_out=254; WIDTH=4, a=15, b=1 -> steps_out=14 (no saturation); counter saturation checked with forced counter.
REQ-038 clear pulse mid-CALC of a=100, b=3 -> IDLE next edge, out_valid never asserts; rst_n pulse mid-CALC -> all outputs 0 immediately, in_ready=1.
